// File: rtl/op_sequencer.sv
// Program sequencer: fetches instruction words from a synchronous ROM, issues ops to CU for a
// fixed execute window, and resolves NOP/HALT/LOOP locally. All outputs are registered.
module op_sequencer #(
    parameter int OP_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 6,
    parameter int PC_WIDTH    = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               hold,
    output logic                               imem_en,
    output logic [PC_WIDTH-1:0]                imem_addr,
    input  logic [OP_WIDTH+3*ADDR_WIDTH-1:0]   imem_rdata,
    output logic [OP_WIDTH-1:0]                opcode,
    output logic [ADDR_WIDTH-1:0]              dst_addr,
    output logic [ADDR_WIDTH-1:0]              src1_addr,
    output logic [ADDR_WIDTH-1:0]              src2_addr,
    output logic                               issue_valid,
    output logic                               busy,
    output logic                               done
);

    localparam int IW = OP_WIDTH + 3 * ADDR_WIDTH;
    localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [EW-1:0] EXEC_INIT = EW'(EXEC_CYCLES - 1);

    localparam logic [OP_WIDTH-1:0] OP_NOP  = {OP_WIDTH{1'b1}};
    localparam logic [OP_WIDTH-1:0] OP_HALT = {{(OP_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [OP_WIDTH-1:0] OP_LOOP = {{(OP_WIDTH-2){1'b1}}, 2'b01};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   loop_cnt_q, loop_cnt_d;
    logic                    loop_armed_q, loop_armed_d;
    logic [EW-1:0]           exec_cnt_q, exec_cnt_d;
    logic [IW-1:0]           instr_q, instr_d;
    logic                    instr_vld_q, instr_vld_d;

    logic                    imem_en_d;
    logic [PC_WIDTH-1:0]     imem_addr_d;
    logic [OP_WIDTH-1:0]     opcode_d;
    logic [ADDR_WIDTH-1:0]   dst_d, src1_d, src2_d;
    logic                    issue_valid_d, busy_d, done_d;

    // Decode source: the word captured while DECODE was held, otherwise the live ROM output.
    logic [IW-1:0]           word;
    logic [OP_WIDTH-1:0]     w_op;
    logic [ADDR_WIDTH-1:0]   w_dst, w_src1, w_src2;
    logic [PC_WIDTH-1:0]     loop_target;
    logic [PC_WIDTH-1:0]     pc_inc;

    assign word = instr_vld_q ? instr_q : imem_rdata;
    assign {w_op, w_dst, w_src1, w_src2} = word;
    assign pc_inc = pc_q + PC_WIDTH'(1);

    generate
        if (PC_WIDTH > ADDR_WIDTH) begin : g_target_ext
            assign loop_target = {{(PC_WIDTH-ADDR_WIDTH){1'b0}}, w_src1};
        end else begin : g_target_trunc
            assign loop_target = w_src1[PC_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned,
        // which is what keeps this block from inferring latches.
        state_d       = state_q;
        pc_d          = pc_q;
        loop_cnt_d    = loop_cnt_q;
        loop_armed_d  = loop_armed_q;
        exec_cnt_d    = exec_cnt_q;
        instr_d       = instr_q;
        instr_vld_d   = instr_vld_q;
        opcode_d      = opcode;
        dst_d         = dst_addr;
        src1_d        = src1_addr;
        src2_d        = src2_addr;
        issue_valid_d = issue_valid;

        if (hold) begin
            // Capture the ROM word once so a long hold in DECODE never depends on ROM output.
            if (state_q == S_DECODE && !instr_vld_q) begin
                instr_d     = imem_rdata;
                instr_vld_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_d    = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Advance only on a cycle where the read really went out (not suppressed by hold).
                    if (imem_en) state_d = S_DECODE;
                end
                S_DECODE: begin
                    instr_d     = word;
                    instr_vld_d = 1'b0;
                    state_d     = S_FETCH;
                    if (w_op == OP_NOP) begin
                        pc_d = pc_inc;
                    end else if (w_op == OP_HALT) begin
                        state_d = S_DONE;
                    end else if (w_op == OP_LOOP) begin
                        if (!loop_armed_q) begin
                            loop_cnt_d = w_dst;
                            if (w_dst != '0) begin
                                loop_armed_d = 1'b1;
                                pc_d         = loop_target;
                            end else begin
                                pc_d = pc_inc;
                            end
                        end else if (loop_cnt_q != ADDR_WIDTH'(1)) begin
                            loop_cnt_d = loop_cnt_q - ADDR_WIDTH'(1);
                            pc_d       = loop_target;
                        end else begin
                            loop_cnt_d   = '0;
                            loop_armed_d = 1'b0;
                            pc_d         = pc_inc;
                        end
                    end else begin
                        opcode_d      = w_op;
                        dst_d         = w_dst;
                        src1_d        = w_src1;
                        src2_d        = w_src2;
                        issue_valid_d = 1'b1;
                        exec_cnt_d    = EXEC_INIT;
                        state_d       = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (exec_cnt_q == '0) begin
                        issue_valid_d = 1'b0;
                        opcode_d      = OP_NOP;
                        pc_d          = pc_inc;
                        state_d       = S_FETCH;
                    end else begin
                        exec_cnt_d = exec_cnt_q - EW'(1);
                    end
                end
                S_DONE: begin
                    loop_armed_d = 1'b0;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are derived from the next state so they can be registered without lag.
        imem_en_d   = !hold && (state_d == S_FETCH);
        imem_addr_d = imem_en_d ? pc_d : imem_addr;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            loop_cnt_q   <= '0;
            loop_armed_q <= 1'b0;
            exec_cnt_q   <= '0;
            instr_q      <= '0;
            instr_vld_q  <= 1'b0;
            imem_en      <= 1'b0;
            imem_addr    <= '0;
            opcode       <= OP_NOP;
            dst_addr     <= '0;
            src1_addr    <= '0;
            src2_addr    <= '0;
            issue_valid  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            loop_cnt_q   <= loop_cnt_d;
            loop_armed_q <= loop_armed_d;
            exec_cnt_q   <= exec_cnt_d;
            instr_q      <= instr_d;
            instr_vld_q  <= instr_vld_d;
            imem_en      <= imem_en_d;
            imem_addr    <= imem_addr_d;
            opcode       <= opcode_d;
            dst_addr     <= dst_d;
            src1_addr    <= src1_d;
            src2_addr    <= src2_d;
            issue_valid  <= issue_valid_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule
